// File: rtl/seq_restoring_divider_if.sv
// Start/busy/done handshake bundle between the ALU control (master) and the
// sequential restoring divider (slave).
interface seq_restoring_divider_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_restoring_divider.sv
// Multi-cycle restoring shift-subtract divider, one quotient bit per clock.
// Define SIGNED_DIV_EN for two's-complement operands (adds one FIXUP cycle).
module seq_restoring_divider #(
    parameter int WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    seq_restoring_divider_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIXUP,
        S_FINISH
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rmd_q, rmd_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;
`ifdef SIGNED_DIV_EN
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
`endif

    logic [WIDTH:0]   rem_shift;
    logic             q_bit;
    logic [WIDTH-1:0] rem_next;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;
`ifdef SIGNED_DIV_EN
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
`endif

        // The partial remainder is always < divisor, so it fits back in WIDTH bits.
        rem_shift = {rem_q, dvd_q[WIDTH-1]};
        q_bit     = (rem_shift >= {1'b0, dsr_q});
        rem_next  = q_bit ? WIDTH'(rem_shift - {1'b0, dsr_q}) : rem_shift[WIDTH-1:0];

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    dbz_d = 1'b0;
                    rem_d = '0;
`ifdef SIGNED_DIV_EN
                    dvd_d     = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
                    dsr_d     = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
                    neg_quo_d = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                    neg_rem_d = bus.dividend[WIDTH-1];
`else
                    dvd_d = bus.dividend;
                    dsr_d = bus.divisor;
`endif
                    if (bus.divisor == '0) begin
                        state_d = S_FINISH;
                        done_d  = 1'b1;
                        dbz_d   = 1'b1;
                        quo_d   = '1;
                        rmd_d   = bus.dividend;
                    end else begin
                        state_d = S_RUN;
                        busy_d  = 1'b1;
                        cnt_d   = CW'(WIDTH);
                    end
                end
            end

            S_RUN: begin
                rem_d = rem_next;
                dvd_d = {dvd_q[WIDTH-2:0], q_bit};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
`ifdef SIGNED_DIV_EN
                    state_d = S_FIXUP;
`else
                    state_d = S_FINISH;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    quo_d   = {dvd_q[WIDTH-2:0], q_bit};
                    rmd_d   = rem_next;
`endif
                end
            end

`ifdef SIGNED_DIV_EN
            // Magnitudes are done; restore signs (quotient toward zero, remainder follows dividend).
            S_FIXUP: begin
                state_d = S_FINISH;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                quo_d   = neg_quo_q ? -dvd_q : dvd_q;
                rmd_d   = neg_rem_q ? -rem_q : rem_q;
            end
`endif

            S_FINISH: state_d = S_IDLE;

            default:  state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            quo_q   <= '0;
            rmd_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
`ifdef SIGNED_DIV_EN
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
`ifdef SIGNED_DIV_EN
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
`endif
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quo_q;
    assign bus.remainder   = rmd_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_restoring_divider.sv
// Bench for seq_restoring_divider: hand-computed vector table, handshake corner
// sequences and random operands against an arithmetic reference model.
module tb_seq_restoring_divider;
    localparam int W = 4;
`ifdef SIGNED_DIV_EN
    localparam int LAT = W + 2;
`else
    localparam int LAT = W + 1;
`endif

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    vec_t vecs[$];

    seq_restoring_divider_if #(.WIDTH(W)) dif ();

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int a, input int b, input int q, input int r, input bit dbz);
        vec_t v;
        v.a = W'(a); v.b = W'(b); v.q = W'(q); v.r = W'(r); v.dbz = dbz;
        return v;
    endfunction

    // Reference: plain integer division as the operand interpretation defines it.
    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic [W-1:0] r,
                                    output logic dbz);
`ifdef SIGNED_DIV_EN
        int sa, sb;
`endif
        if (b == '0) begin
            q = '1; r = a; dbz = 1'b1;
        end else begin
`ifdef SIGNED_DIV_EN
            sa = $signed(a);
            sb = $signed(b);
            q  = W'(sa / sb);
            r  = W'(sa % sb);
`else
            q  = a / b;
            r  = a % b;
`endif
            dbz = 1'b0;
        end
    endfunction

    task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] eq, input logic [W-1:0] er, input logic edbz);
        int lat, busy_n, done_n, exp_lat;
        logic [W-1:0] q_prev, r_prev, q_done, r_done;
        bit held;
        exp_lat = (b == '0) ? 1 : LAT;
        q_prev = dif.quotient; r_prev = dif.remainder;
        q_done = '0; r_done = '0;
        held = 1'b1; lat = -1; busy_n = 0; done_n = 0;
        @(negedge clk);
        dif.start = 1'b1; dif.dividend = a; dif.divisor = b;
        @(posedge clk);
        #1;
        dif.start = 1'b0;
        dif.dividend = W'($urandom);
        dif.divisor  = W'($urandom);
        for (int c = 1; c <= LAT + 3; c++) begin
            @(negedge clk);
            if (dif.busy) busy_n++;
            if (dif.done) begin
                done_n++;
                if (lat < 0) begin
                    lat = c; q_done = dif.quotient; r_done = dif.remainder;
                end
            end
            if (lat < 0 && (dif.quotient !== q_prev || dif.remainder !== r_prev)) held = 1'b0;
        end
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " done_pulses"}, done_n, 1);
        check({tag, " busy_cycles"}, busy_n, exp_lat - 1);
        check({tag, " q_at_done"}, q_done, eq);
        check({tag, " r_at_done"}, r_done, er);
        check({tag, " q_held"}, dif.quotient, eq);
        check({tag, " r_held"}, dif.remainder, er);
        check({tag, " div_by_zero"}, dif.div_by_zero, edbz);
        check({tag, " prev_result_stable"}, held, 1'b1);
    endtask

    task automatic run_ref(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] q, r;
        logic dbz;
        ref_div(a, b, q, r, dbz);
        run_div(tag, a, b, q, r, dbz);
    endtask

    initial begin
        logic [W-1:0] eq, er;
        logic edbz;
        int done_n, first_done, second_done;

        n_checks = 0; n_fail = 0;
`ifdef SIGNED_DIV_EN
        vecs.push_back(mk(-7,  2, -3, -1, 1'b0));
        vecs.push_back(mk(-8, -1, -8,  0, 1'b0));
        vecs.push_back(mk( 7, -2, -3,  1, 1'b0));
        vecs.push_back(mk(-6,  3, -2,  0, 1'b0));
        vecs.push_back(mk( 3, -7,  0,  3, 1'b0));
        vecs.push_back(mk( 5,  0, -1,  5, 1'b1));
        vecs.push_back(mk(-5,  0, -1, -5, 1'b1));
        vecs.push_back(mk( 6,  2,  3,  0, 1'b0));
`else
        vecs.push_back(mk(13,  3,  4, 1, 1'b0));
        vecs.push_back(mk(15,  1, 15, 0, 1'b0));
        vecs.push_back(mk( 5,  7,  0, 5, 1'b0));
        vecs.push_back(mk(15, 15,  1, 0, 1'b0));
        vecs.push_back(mk( 0,  9,  0, 0, 1'b0));
        vecs.push_back(mk( 9,  0, 15, 9, 1'b1));
        vecs.push_back(mk( 8,  2,  4, 0, 1'b0));
        vecs.push_back(mk(10,  4,  2, 2, 1'b0));
        vecs.push_back(mk( 1, 15,  0, 1, 1'b0));
        vecs.push_back(mk(14,  5,  2, 4, 1'b0));
`endif

        rst_n = 1'b0;
        dif.start = 1'b0; dif.dividend = '0; dif.divisor = '0;
        repeat (2) @(negedge clk);
        check("reset busy", dif.busy, 1'b0);
        check("reset done", dif.done, 1'b0);
        check("reset quotient", dif.quotient, '0);
        check("reset remainder", dif.remainder, '0);
        check("reset div_by_zero", dif.div_by_zero, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i])
            run_div($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dbz);

        // Flag from a divide-by-zero persists until the next accepted start.
        run_ref("dbz_set", W'(9), W'(0));
        repeat (3) @(negedge clk);
        check("dbz_persist", dif.div_by_zero, 1'b1);
        run_ref("dbz_clear", W'(8), W'(2));

        // start pulsed in RUN cycle 2 must be ignored.
        ref_div(W'(6), W'(3), eq, er, edbz);
        done_n = 0; first_done = -1;
        @(negedge clk);
        dif.start = 1'b1; dif.dividend = W'(6); dif.divisor = W'(3);
        @(posedge clk);
        #1 dif.start = 1'b0;
        for (int c = 1; c <= LAT + 3; c++) begin
            @(negedge clk);
            if (dif.done) begin
                done_n++;
                if (first_done < 0) first_done = c;
            end
            if (c == 2) begin
                dif.start = 1'b1; dif.dividend = W'(5); dif.divisor = W'(1);
            end else begin
                dif.start = 1'b0;
            end
        end
        check("busy_start done_pulses", done_n, 1);
        check("busy_start latency", first_done, LAT);
        check("busy_start quotient", dif.quotient, eq);
        check("busy_start remainder", dif.remainder, er);

        // Reset in RUN cycle 3 clears everything at once and aborts the division.
        @(negedge clk);
        dif.start = 1'b1; dif.dividend = W'(13); dif.divisor = W'(3);
        @(posedge clk);
        #1 dif.start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort busy", dif.busy, 1'b0);
        check("abort done", dif.done, 1'b0);
        check("abort quotient", dif.quotient, '0);
        check("abort remainder", dif.remainder, '0);
        check("abort div_by_zero", dif.div_by_zero, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        done_n = 0;
        repeat (LAT + 2) begin
            @(negedge clk);
            if (dif.done) done_n++;
        end
        check("abort no_done", done_n, 0);
        run_ref("after_abort", W'(10), W'(4));

        // start held high: a second division begins on the first IDLE cycle after FINISH.
        ref_div(W'(7), W'(2), eq, er, edbz);
        done_n = 0; first_done = -1; second_done = -1;
        @(negedge clk);
        dif.start = 1'b1; dif.dividend = W'(7); dif.divisor = W'(2);
        @(posedge clk);
        for (int c = 1; c <= 2 * LAT + 4; c++) begin
            @(negedge clk);
            if (dif.done) begin
                done_n++;
                if (first_done < 0) first_done = c;
                else if (second_done < 0) second_done = c;
            end
            if (c == LAT + 2) dif.start = 1'b0;
        end
        check("held_start done_pulses", done_n, 2);
        check("held_start first_done", first_done, LAT);
        check("held_start second_done", second_done, 2 * LAT + 1);
        check("held_start quotient", dif.quotient, eq);
        check("held_start remainder", dif.remainder, er);

        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] a, b;
            a = W'($urandom);
            b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            run_ref($sformatf("rand%0d", i), a, b);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
